// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a = sum - b, LSB first, with start/ready/done handshake and an out-of-range flag
// Ports: clk, rst_n (sync, active-low); start, sum[W:0], b[W-1:0] in; ready, a[W-1:0], err, done out (all registered)
module serial_subtractor #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W:0]   sum,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic [W-1:0] a,
  output logic         err,
  output logic         done
);
  localparam int CW = $clog2(W + 2);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [W:0] sreg, breg, diff, diff_nx;
  logic [CW-1:0] cnt;
  logic borrow, d, borrow_nx;
  always_comb begin
    d = sreg[0] ^ breg[0] ^ borrow;
    borrow_nx = (~sreg[0] & breg[0]) | (~(sreg[0] ^ breg[0]) & borrow);
    diff_nx = {d, diff[W:1]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      a <= '0;
      err <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      borrow <= 1'b0;
      sreg <= '0;
      breg <= '0;
      diff <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sreg <= sum;
            breg <= {1'b0, b};
            borrow <= 1'b0;
            cnt <= '0;
            ready <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          diff <= diff_nx;
          sreg <= sreg >> 1;
          breg <= breg >> 1;
          borrow <= borrow_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W)) begin
            a <= diff_nx[W-1:0];
            err <= diff_nx[W] | borrow_nx;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor at W=2 and W=4
module tb_serial_subtractor;
  logic clk, rst_n;
  logic s2_start, s2_ready, s2_err, s2_done;
  logic [2:0] s2_sum;
  logic [1:0] s2_b, s2_a;
  logic s4_start, s4_ready, s4_err, s4_done;
  logic [4:0] s4_sum;
  logic [3:0] s4_b, s4_a;
  int n_checks, n_fail;

  serial_subtractor #(.W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2_start), .sum(s2_sum), .b(s2_b),
    .ready(s2_ready), .a(s2_a), .err(s2_err), .done(s2_done)
  );
  serial_subtractor #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .sum(s4_sum), .b(s4_b),
    .ready(s4_ready), .a(s4_a), .err(s4_err), .done(s4_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op2(input logic [2:0] s, input logic [1:0] bb,
                        output logic [1:0] ra, output logic re, output int lat);
    s2_sum = s; s2_b = bb; s2_start = 1'b1;
    tick();
    s2_start = 1'b0;
    lat = 0;
    while (!s2_done && lat < 20) begin
      tick();
      lat++;
    end
    ra = s2_a; re = s2_err;
    tick();
  endtask

  task automatic do_op4(input logic [4:0] s, input logic [3:0] bb,
                        output logic [3:0] ra, output logic re, output int lat);
    s4_sum = s; s4_b = bb; s4_start = 1'b1;
    tick();
    s4_start = 1'b0;
    lat = 0;
    while (!s4_done && lat < 20) begin
      tick();
      lat++;
    end
    ra = s4_a; re = s4_err;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({s2_ready, s2_a, s2_err, s2_done} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_w2: got ready/a/err/done=%b want 10000", {s2_ready, s2_a, s2_err, s2_done});
    end
    n_checks++;
    if ({s4_ready, s4_a, s4_err, s4_done} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_w4: got ready/a/err/done=%b want 1000000", {s4_ready, s4_a, s4_err, s4_done});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    s2_sum = 3'd5; s2_b = 2'd2; s2_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      s2_start = 1'b0;
      n_checks++;
      if (s2_ready !== (k == 4) || s2_done !== (k == 3)) begin
        n_fail++;
        $display("FAIL basic_handshake k=%0d: got ready=%b done=%b want ready=%b done=%b",
                 k, s2_ready, s2_done, k == 4, k == 3);
      end
      if (k == 3) begin
        n_checks++;
        if (s2_a !== 2'd3 || s2_err !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_result: got a=%0d err=%b want a=3 err=0", s2_a, s2_err);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0] vs [3] = '{3'd1, 3'd7, 3'd3};
    logic [1:0] vb [3] = '{2'd2, 2'd1, 2'd3};
    logic [1:0] va [3] = '{2'd3, 2'd2, 2'd0};
    logic ve [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] ra;
    logic re;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op2(vs[i], vb[i], ra, re, lat);
      n_checks++;
      if (ra !== va[i] || re !== ve[i] || lat != 3) begin
        n_fail++;
        $display("FAIL errors sum=%0d b=%0d: got a=%0d err=%b lat=%0d want a=%0d err=%b lat=3",
                 vs[i], vb[i], ra, re, lat, va[i], ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int accepts = 0, dones = 0, pending = 0;
    logic prev_ready;
    s2_sum = 3'd5; s2_b = 2'd2; s2_start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      prev_ready = s2_ready;
      tick();
      if (prev_ready) begin
        accepts++;
        pending++;
        n_checks++;
        if (pending > 1) begin
          n_fail++;
          $display("FAIL b2b_double_accept k=%0d: got %0d pending ops want 1", k, pending);
        end
      end
      if (s2_done) begin
        dones++;
        pending--;
        n_checks++;
        if (s2_a !== 2'd3 || s2_err !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_result k=%0d: got a=%0d err=%b want a=3 err=0", k, s2_a, s2_err);
        end
      end
      s2_sum = s2_ready ? 3'd5 : 3'(k);
      s2_b = s2_ready ? 2'd2 : ~2'(k);
    end
    s2_start = 1'b0;
    n_checks++;
    if (accepts != 4 || dones != 4) begin
      n_fail++;
      $display("FAIL b2b_counts: got accepts=%0d dones=%0d want 4 and 4", accepts, dones);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [1:0] ra;
    logic re;
    int lat;
    int seen = 0;
    s2_sum = 3'd6; s2_b = 2'd1; s2_start = 1'b1;
    tick();
    s2_start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({s2_ready, s2_a, s2_err, s2_done} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_mid_state: got ready/a/err/done=%b want 10000", {s2_ready, s2_a, s2_err, s2_done});
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (s2_done || !s2_ready) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got %0d cycles with done=1 or ready=0 want 0", seen);
    end
    do_op2(3'd4, 2'd1, ra, re, lat);
    n_checks++;
    if (ra !== 2'd3 || re !== 1'b0 || lat != 3) begin
      n_fail++;
      $display("FAIL reset_mid_next: got a=%0d err=%b lat=%0d want a=3 err=0 lat=3", ra, re, lat);
    end
  endtask

  task automatic test_roundtrip();
    logic [3:0] ra;
    logic re;
    int lat;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        do_op4(5'(x + y), 4'(y), ra, re, lat);
        n_checks++;
        if (ra !== 4'(x) || re !== 1'b0 || lat != 5) begin
          n_fail++;
          $display("FAIL roundtrip a0=%0d b=%0d: got a=%0d err=%b lat=%0d want a=%0d err=0 lat=5",
                   x, y, ra, re, lat, x);
        end
      end
  endtask

  task automatic test_reset_hold();
    int lat = 0;
    rst_n = 1'b0;
    s2_sum = 3'd5; s2_b = 2'd2; s2_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (s2_ready !== 1'b1 || s2_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d: got ready=%b done=%b want ready=1 done=0", k, s2_ready, s2_done);
      end
    end
    rst_n = 1'b1;
    tick();
    s2_start = 1'b0;
    n_checks++;
    if (s2_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_accept: got ready=%b want 0", s2_ready);
    end
    while (!s2_done && lat < 20) begin
      tick();
      lat++;
    end
    n_checks++;
    if (s2_a !== 2'd3 || s2_err !== 1'b0 || lat != 3) begin
      n_fail++;
      $display("FAIL reset_release_result: got a=%0d err=%b lat=%0d want a=3 err=0 lat=3", s2_a, s2_err, lat);
    end
    tick();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    s2_start = 1'b0; s2_sum = '0; s2_b = '0;
    s4_start = 1'b0; s4_sum = '0; s4_b = '0;
    test_reset();
    test_basic();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_roundtrip();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial inverse of the W-bit registered adder. It takes a (W+1)-bit sum and one W-bit addend and recovers the other addend: a = sum - b. Processing is LSB first, one bit per clock, with a start/ready/done handshake. It flags any result that does not fit in W unsigned bits. It is used to check the adder datapath and to unpack stored sums where area matters more than latency.

Parameters:
W, 2, operand width; sum input is W+1 bits, result is W bits; legal W >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request; accepted only on an edge where ready=1 and rst_n=1
sum  input  W+1  minuend; captured on accept edge only
b  input  W  subtrahend; captured on accept edge only, zero-extended to W+1 bits
ready  output  1  registered; 1 in IDLE, 0 otherwise
a  output  W  registered result, low W bits of sum-b (mod 2^W)
err  output  1  registered; 1 if sum<b (borrow out) or sum-b >= 2^W
done  output  1  registered one-cycle pulse: a/err updated this cycle

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at an edge): state=IDLE, ready=1, a=0, err=0, done=0, bit counter=0, borrow=0, shift registers=0. Reset mid-operation aborts silently: no done pulse, and the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1, done=0. At an edge with start=1, capture sum into sreg and {1'b0,b} into breg, clear borrow and cnt, then go to SHIFT with ready=0. If start=0, stay in IDLE.
- SHIFT: each edge processes bit i=cnt.
  - d = sreg[0] ^ breg[0] ^ borrow
  - borrow_next = (~sreg[0] & breg[0]) | (~(sreg[0] ^ breg[0]) & borrow)
  - Shift d into the MSB of the result shift register; shift sreg and breg right; cnt++.
  - The edge that processes bit W (cnt==W) goes to DONE, loads a = diff[W-1:0] and err = diff[W] | borrow_next, and sets done=1.
- DONE: lasts exactly one cycle with done=1, ready=0. Next edge: IDLE, done=0, ready=1.
- Latency: accept edge E0. Bits 0..W are processed on edges E1..E(W+1). done is high in the cycle after E(W+1). The next accept is possible at E(W+3). Throughput is one op per W+3 cycles.
- start while ready=0 is ignored and not queued. start held high continuously restarts at every IDLE.
- sum/b changes after the accept edge do not affect the result.
- a and err hold their last values until the next done pulse or reset. a and err are not cleared on start.
- Arithmetic: unsigned. diff = (sum - {0,b}) mod 2^(W+1). The err cases are:
  - sum<b: err=1, a = two's-complement wrap.
  - sum-b in [2^W, 2^(W+1)-1]: err=1, a = low W bits.
- Round-trip property: for all a0,b in [0,2^W-1], sum=a0+b gives a=a0, err=0.
- cnt width is clog2(W+2). There is no combinational path from inputs to outputs.

Test Plan:
- W=2, reset then sum=5,b=2,start=1 for one cycle -> ready=0 for 4 cycles; done=1 exactly 3 cycles after accept edge with a=3, err=0; ready=1 one cycle later.
- W=2, sum=1,b=2 -> a=2'b11, err=1; sum=7,b=1 -> a=2, err=1 (overflow); sum=3,b=3 -> a=0, err=0.
- W=2, start held high 20 cycles -> accepts every 5th edge, one done pulse per op, never two accepts without an intervening done; sum/b toggled mid-op do not change the result.
- rst_n=0 for one edge on the second SHIFT cycle of sum=6,b=1 -> next cycle ready=1, a=0, err=0, done=0; no done pulse follows; a new op sum=4,b=1 then gives a=3, err=0.
- W=4 exhaustive round-trip: all a0,b in 0..15 with sum=a0+b -> a=a0, err=0 for all 256 cases, each done 5 cycles after accept.
- rst_n=0 held for 3 cycles with start=1 -> no accept while in reset; ready=1 and accept on the first edge with rst_n=1.
